// File: rtl/gshare_branch_predictor_if.sv
// Fetch/resolve bundle between the TCORE fetch stage, execute and the gshare predictor.
interface gshare_branch_predictor_if #(
  parameter int unsigned HW = 8
);
  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
  } predict_info_t;

  logic          fetch_valid_i;
  logic          fetch_ready_i;
  logic [31:0]   fetch_pc_i;
  logic [31:0]   fetch_rdata_i;
  predict_info_t spec_o;
  logic [HW-1:0] spec_ghr_o;
  logic          upd_valid_i;
  logic [31:0]   upd_pc_i;
  logic [HW-1:0] upd_ghr_i;
  logic          upd_taken_i;
  logic          upd_mispredict_i;

  modport master (
    output fetch_valid_i, fetch_ready_i, fetch_pc_i, fetch_rdata_i,
    output upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
    input  spec_o, spec_ghr_o
  );

  modport slave (
    input  fetch_valid_i, fetch_ready_i, fetch_pc_i, fetch_rdata_i,
    input  upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
    output spec_o, spec_ghr_o
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare (or bimodal when HIST_LEN=0) direction predictor with RV32IMC pre-decode
// for the TCORE fetch stage; trained and history-repaired from execute.
module gshare_branch_predictor #(
  parameter int unsigned PHT_ENTRIES    = 256,
  parameter int unsigned HIST_LEN       = 8,
  parameter logic [31:0] TAKEN_PC_LIMIT = 32'h4000_3D00
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  gshare_branch_predictor_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(PHT_ENTRIES);
  localparam int unsigned HW    = (HIST_LEN > 0) ? HIST_LEN : 1;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [HW-1:0] ghr_push(input logic [HW-1:0] h, input logic b);
    return HW'({h, b});
  endfunction

  logic [1:0]        pht_q [PHT_ENTRIES];
  logic [HW-1:0]     ghr_q;
  logic [31:0]       instr;
  logic              is_j, is_b, is_cj, is_cb, is_cond;
  logic signed [31:0] imm_j, imm_b, imm_cj, imm_cb, imm_sel;
  logic [31:0]       target;
  logic [IDX_W-1:0]  fetch_idx, upd_idx, upd_ghr_ext;
  logic              ctr_bit, spec_taken;

  assign instr   = bp.fetch_rdata_i;
  assign is_j    = (instr[6:0] == 7'h6f);
  assign is_b    = (instr[6:0] == 7'h63);
  assign is_cj   = (instr[1:0] == 2'b01) && ((instr[15:13] == 3'b001) || (instr[15:13] == 3'b101));
  assign is_cb   = (instr[1:0] == 2'b01) && (instr[15:14] == 2'b11);
  assign is_cond = is_b | is_cb;

  assign imm_j  = $signed({{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0});
  assign imm_b  = $signed({{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0});
  assign imm_cj = $signed({{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                           instr[2], instr[11], instr[5:3], 1'b0});
  assign imm_cb = $signed({{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0});

  always_comb begin
    imm_sel = imm_b;
    if (is_j)       imm_sel = imm_j;
    else if (is_cj) imm_sel = imm_cj;
    else if (is_cb) imm_sel = imm_cb;
  end

  // Adder always runs, so the target stays deterministic even without a valid fetch.
  assign target    = bp.fetch_pc_i + $unsigned(imm_sel);
  assign fetch_idx = bp.fetch_pc_i[IDX_W:1] ^ IDX_W'(ghr_q);
  assign upd_idx   = bp.upd_pc_i[IDX_W:1] ^ upd_ghr_ext;
  assign ctr_bit   = pht_q[fetch_idx][1];

  assign spec_taken     = bp.fetch_valid_i & (is_j | is_cj | (is_cond & ctr_bit))
                        & (target < TAKEN_PC_LIMIT);
  assign bp.spec_o      = {spec_taken, target};
  assign bp.spec_ghr_o  = ghr_q;

  // Counter training; a same-cycle fetch read of this entry still sees the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
    end else if (bp.upd_valid_i) begin
      pht_q[upd_idx] <= bp.upd_taken_i ? sat_inc(pht_q[upd_idx]) : sat_dec(pht_q[upd_idx]);
    end
  end

  generate
    if (HIST_LEN > 0) begin : g_ghr
      assign upd_ghr_ext = IDX_W'(bp.upd_ghr_i);

      // Execute repair wins over the speculative shift; the shift uses the unmasked counter bit.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ghr_q <= '0;
        end else if (bp.upd_valid_i && bp.upd_mispredict_i) begin
          ghr_q <= ghr_push(bp.upd_ghr_i, bp.upd_taken_i);
        end else if (bp.fetch_valid_i && bp.fetch_ready_i && is_cond) begin
          ghr_q <= ghr_push(ghr_q, ctr_bit);
        end
      end
    end else begin : g_bimodal
      assign upd_ghr_ext = '0;
      assign ghr_q       = '0;
    end
  endgenerate
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: gshare (HIST_LEN=8) and bimodal (HIST_LEN=0) instances.
module tb_gshare_branch_predictor;
  localparam logic [31:0] JAL8 = 32'h0080_006f;
  localparam logic [31:0] BEQ8 = 32'h0000_0463;
  localparam logic [31:0] BNE8 = 32'h0000_1463;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gshare_branch_predictor_if #(.HW(8)) g_if ();
  gshare_branch_predictor_if #(.HW(1)) b_if ();

  gshare_branch_predictor #(.HIST_LEN(8)) u_gsh (.clk_i(clk), .rst_ni(rst_n), .bp(g_if));
  gshare_branch_predictor #(.HIST_LEN(0)) u_bim (.clk_i(clk), .rst_ni(rst_n), .bp(b_if));

  typedef struct {
    string       name;
    bit          bim;
    bit          ck_t;
    bit          exp_t;
    bit          ck_pc;
    logic [31:0] exp_pc;
    bit          ck_g;
    logic [7:0]  exp_g;
  } exp_s;

  exp_s sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every queued expectation is checked at the next falling edge.
  always @(negedge clk) begin
    exp_s e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.bim) begin
        if (e.ck_t)  cmp({e.name, ".taken"}, {31'b0, b_if.spec_o.taken}, {31'b0, e.exp_t});
        if (e.ck_pc) cmp({e.name, ".pc"}, b_if.spec_o.pc, e.exp_pc);
        if (e.ck_g)  cmp({e.name, ".ghr"}, {31'b0, b_if.spec_ghr_o}, {24'b0, e.exp_g});
      end else begin
        if (e.ck_t)  cmp({e.name, ".taken"}, {31'b0, g_if.spec_o.taken}, {31'b0, e.exp_t});
        if (e.ck_pc) cmp({e.name, ".pc"}, g_if.spec_o.pc, e.exp_pc);
        if (e.ck_g)  cmp({e.name, ".ghr"}, {24'b0, g_if.spec_ghr_o}, {24'b0, e.exp_g});
      end
    end
  end

  task automatic expect_o(input string n, input bit bim, input bit ck_t, input bit t,
                          input bit ck_pc, input logic [31:0] pc, input bit ck_g, input logic [7:0] g);
    exp_s e;
    e.name = n; e.bim = bim; e.ck_t = ck_t; e.exp_t = t;
    e.ck_pc = ck_pc; e.exp_pc = pc; e.ck_g = ck_g; e.exp_g = g;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic g_fetch(input bit v, input bit r, input logic [31:0] pc, input logic [31:0] ins);
    g_if.fetch_valid_i = v; g_if.fetch_ready_i = r;
    g_if.fetch_pc_i = pc;   g_if.fetch_rdata_i = ins;
  endtask

  task automatic g_upd(input bit v, input logic [31:0] pc, input logic [7:0] ghr, input bit t, input bit m);
    g_if.upd_valid_i = v; g_if.upd_pc_i = pc; g_if.upd_ghr_i = ghr;
    g_if.upd_taken_i = t; g_if.upd_mispredict_i = m;
  endtask

  // Bimodal updates always carry a mispredict flag and a nonzero history, which must be ignored.
  task automatic b_upd(input bit v, input bit t);
    b_if.upd_valid_i = v; b_if.upd_pc_i = 32'h100; b_if.upd_ghr_i = 1'b1;
    b_if.upd_taken_i = t; b_if.upd_mispredict_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    g_fetch(1, 1, 32'h4000_0000, JAL8);
    g_upd(0, 32'h0, 8'h00, 1'b0, 1'b0);
    b_if.fetch_valid_i = 1'b1; b_if.fetch_ready_i = 1'b1;
    b_if.fetch_pc_i = 32'h100; b_if.fetch_rdata_i = BEQ8;
    b_upd(0, 1'b0);
    expect_o("rst_jal", 0, 1, 1, 1, 32'h4000_0008, 1, 8'h00);
    expect_o("rst_beq", 1, 1, 0, 1, 32'h0000_0108, 1, 8'h00);
    #12 rst_n = 1'b1;
    tick();

    // Unconditional jumps and target limit
    expect_o("jal", 0, 1, 1, 1, 32'h4000_0008, 1, 8'h00);
    tick();
    expect_o("jal_ghr", 0, 0, 0, 0, 32'h0, 1, 8'h00);
    g_fetch(1, 1, 32'h0000_0200, 32'hDEAD_BFFD);
    expect_o("cj_neg", 0, 1, 1, 1, 32'h0000_01FE, 1, 8'h00);
    tick();
    g_fetch(1, 1, 32'h4000_3CF8, JAL8);
    expect_o("jal_limit", 0, 1, 0, 1, 32'h4000_3D00, 0, 8'h00);
    tick();
    g_fetch(1, 1, 32'h4000_3CF0, JAL8);
    expect_o("jal_below_limit", 0, 1, 1, 1, 32'h4000_3CF8, 0, 8'h00);
    tick();
    g_fetch(0, 1, 32'h4000_0000, JAL8);
    expect_o("invalid", 0, 1, 0, 1, 32'h4000_0008, 1, 8'h00);
    tick();
    g_fetch(1, 0, 32'h0000_0300, 32'h0000_C011);
    expect_o("cb_pos", 0, 1, 0, 1, 32'h0000_0304, 1, 8'h00);
    tick();
    g_fetch(1, 0, 32'h0000_0300, 32'h0000_DC7D);
    expect_o("cb_neg", 0, 1, 0, 1, 32'h0000_02FE, 1, 8'h00);
    tick();

    // Stall with a not-taken prediction: one shift of 0
    g_fetch(1, 0, 32'h100, BEQ8);
    for (int i = 0; i < 3; i++) begin
      expect_o("stall_nt", 0, 1, 0, 1, 32'h108, 1, 8'h00);
      tick();
    end
    g_fetch(1, 1, 32'h100, BEQ8);
    expect_o("adv_nt", 0, 1, 0, 0, 32'h0, 1, 8'h00);
    tick();
    g_fetch(0, 1, 32'h100, BEQ8);
    expect_o("shift0", 0, 0, 0, 0, 32'h0, 1, 8'h00);

    // Train index 0x80 (pc 0x100, ghr 0); correct-path update leaves GHR alone
    g_upd(1, 32'h100, 8'h00, 1'b1, 1'b0);
    tick();
    g_upd(0, 32'h0, 8'h00, 1'b0, 1'b0);
    expect_o("train_noghr", 0, 0, 0, 0, 32'h0, 1, 8'h00);
    g_fetch(1, 0, 32'h100, BEQ8);
    for (int i = 0; i < 3; i++) begin
      expect_o("stall_t", 0, 1, 1, 0, 32'h0, 1, 8'h00);
      tick();
    end
    g_fetch(1, 1, 32'h100, BEQ8);
    expect_o("adv_t", 0, 1, 1, 0, 32'h0, 1, 8'h00);
    tick();
    g_fetch(1, 0, 32'h100, BEQ8);
    expect_o("shift1", 0, 1, 0, 0, 32'h0, 1, 8'h01);
    tick();

    // Taken counter behind the target limit: masked prediction, but history still gets a 1
    g_fetch(0, 0, 32'h100, BEQ8);
    g_upd(1, 32'h4000_3CF8, 8'h01, 1'b1, 1'b0);
    tick();
    g_upd(0, 32'h0, 8'h00, 1'b0, 1'b0);
    g_fetch(1, 1, 32'h4000_3CF8, BEQ8);
    expect_o("b_limit", 0, 1, 0, 1, 32'h4000_3D00, 1, 8'h01);
    tick();
    g_fetch(0, 1, 32'h100, BEQ8);
    expect_o("mask_shift", 0, 0, 0, 0, 32'h0, 1, 8'h03);

    // Mispredict repair, including a simultaneous conditional fetch
    g_upd(1, 32'h0, 8'h1E, 1'b0, 1'b1);
    tick();
    g_upd(0, 32'h0, 8'h00, 1'b0, 1'b0);
    expect_o("restore_3c", 0, 0, 0, 0, 32'h0, 1, 8'h3C);
    g_upd(1, 32'h0, 8'h5A, 1'b1, 1'b1);
    g_fetch(1, 1, 32'h100, BNE8);
    tick();
    g_upd(0, 32'h0, 8'h00, 1'b0, 1'b0);
    g_fetch(0, 1, 32'h100, BNE8);
    expect_o("restore_b5", 0, 0, 0, 0, 32'h0, 1, 8'hB5);
    g_upd(0, 32'h100, 8'h00, 1'b1, 1'b1);
    tick();
    tick();
    expect_o("upd_invalid", 0, 0, 0, 0, 32'h0, 1, 8'hB5);
    g_upd(0, 32'h0, 8'h00, 1'b0, 1'b0);

    // GHR=0xFF and index 0x7F trained, then async reset between edges
    g_upd(1, 32'h0, 8'h7F, 1'b1, 1'b1);
    tick();
    g_upd(0, 32'h0, 8'h00, 1'b0, 1'b0);
    g_fetch(1, 0, 32'h100, BEQ8);
    expect_o("pre_rst", 0, 1, 1, 0, 32'h0, 1, 8'hFF);
    tick();
    rst_n = 1'b0;
    expect_o("rst_async", 0, 1, 0, 0, 32'h0, 1, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    expect_o("rst_pht80", 0, 1, 0, 0, 32'h0, 1, 8'h00);
    tick();
    g_fetch(1, 0, 32'h0FE, BEQ8);
    expect_o("rst_pht7f", 0, 1, 0, 0, 32'h0, 1, 8'h00);
    tick();
    g_fetch(1, 0, 32'h4000_0000, JAL8);
    expect_o("rst_jal_after", 0, 1, 1, 0, 32'h0, 1, 8'h00);
    tick();
    g_fetch(0, 0, 32'h0, 32'h0);

    // Bimodal saturation at pc 0x100 (instance untouched since reset)
    expect_o("bim_init", 1, 1, 0, 0, 32'h0, 1, 8'h00);
    b_upd(1, 1'b1);
    tick();
    b_upd(0, 1'b0);
    expect_o("bim_1t", 1, 1, 1, 0, 32'h0, 0, 8'h00);
    b_upd(1, 1'b1);
    repeat (3) tick();
    b_upd(0, 1'b0);
    expect_o("bim_4t", 1, 1, 1, 0, 32'h0, 1, 8'h00);
    b_upd(1, 1'b0);
    tick();
    b_upd(0, 1'b0);
    expect_o("bim_sat_nt1", 1, 1, 1, 0, 32'h0, 0, 8'h00);
    b_upd(1, 1'b0);
    tick();
    b_upd(0, 1'b0);
    expect_o("bim_nt2", 1, 1, 0, 0, 32'h0, 0, 8'h00);
    b_upd(1, 1'b0);
    repeat (5) tick();
    b_upd(1, 1'b1);
    tick();
    b_upd(0, 1'b0);
    expect_o("bim_00_t1", 1, 1, 0, 0, 32'h0, 1, 8'h00);
    b_upd(1, 1'b1);
    tick();
    b_upd(0, 1'b0);
    expect_o("bim_00_t2", 1, 1, 1, 1, 32'h108, 1, 8'h00);
    tick();

    repeat (20) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised dynamic branch predictor for the TCORE fetch stage, replacing the two-entry signed/unsigned FSM with a table of 2-bit saturating counters. The table is indexed by fetch PC XOR a global history register (gshare), or by PC alone when `HIST_LEN=0` (bimodal). It pre-decodes JAL, B, C.J/C.JAL and C.BEQZ/C.BNEZ from the fetched word and produces `predict_info_t` combinationally. Counters are trained, and history is repaired, from a resolve port driven by execute.

## Interface
- `PHT_ENTRIES`, 256: number of counters. Power of 2, ≥4. `IDX_W = $clog2(PHT_ENTRIES)`.
- `HIST_LEN`, 8: GHR bits, range 0..`IDX_W`. With 0 the block is bimodal and the GHR is a 1-bit constant 0. `HW = max(HIST_LEN,1)`.
- `TAKEN_PC_LIMIT`, 32'h4000_3D00: predicted targets ≥ this value are never predicted taken.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `fetch_valid_i`, in, 1: `fetch_rdata_i` and `fetch_pc_i` hold a valid instruction.
- `fetch_ready_i`, in, 1: fetch advances this cycle. The GHR may shift only when this is 1.
- `fetch_pc_i`, in, 32: PC of the fetched instruction.
- `fetch_rdata_i`, in, 32: fetched instruction. For compressed instructions, [15:0] is used.
- `spec_o`, out, `predict_info_t`: `.taken` and `.pc` (predicted target).
- `spec_ghr_o`, out, HW: GHR value used for the current prediction. Fetch carries it down the pipe.
- `upd_valid_i`, in, 1: a resolved conditional branch (B or CB) is reported.
- `upd_pc_i`, in, 32: PC of the resolved branch.
- `upd_ghr_i`, in, HW: `spec_ghr_o` captured when that branch was predicted.
- `upd_taken_i`, in, 1: actual outcome.
- `upd_mispredict_i`, in, 1: direction was mispredicted. Qualified by `upd_valid_i`.

## Operation
- Decode is identical to the TCORE pre-decode:
  - J: opcode 7'h6f.
  - B: opcode 7'h63.
  - CJ: [1:0]=01 and funct3 ∈ {001,101}.
  - CB: [1:0]=01 and funct3 ∈ {110,111}.
  - Immediates use the standard RV32IMC J/B/CJ/CB layouts, sign-extended.
- Target: `spec_o.pc = fetch_pc_i + imm`, modulo 2^32. When no class matches, the B immediate is used.
- Index: `idx(pc,ghr) = pc[IDX_W:1] ^ {{(IDX_W-HIST_LEN){0}}, ghr}`. Bit 1 is included because of compressed PCs. Fetch uses `(fetch_pc_i, ghr_q)`; update uses `(upd_pc_i, upd_ghr_i)`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when bit 1 is set.
- `spec_o.taken = fetch_valid_i & (J | CJ | ((B|CB) & pht[idx][1])) & (spec_o.pc < TAKEN_PC_LIMIT)`.
- Training, when `upd_valid_i`:
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- GHR (`HIST_LEN>0`), highest priority first:
  1. If `upd_valid_i & upd_mispredict_i`: `ghr_q <= {upd_ghr_i[HW-2:0], upd_taken_i}`. For `HIST_LEN=1` this is `upd_taken_i`.
  2. Else if `fetch_valid_i & fetch_ready_i & (B|CB)`: `ghr_q <= {ghr_q[HW-2:0], predicted direction}`.
  3. Else hold.
  - The predicted direction is the counter bit before the target-limit mask.
- J and CJ never touch the GHR or the PHT.
- `spec_ghr_o = ghr_q`.

## Timing
- Prediction is combinational, with zero latency from the fetch inputs to `spec_o`.
- PHT and GHR writes are visible the cycle after the edge.
- Read/write collision on the same index in one cycle: the read returns the old counter. No bypass.
- Reset, asynchronous, also mid-operation:
  - All counters become 01 and `ghr_q` becomes 0 immediately.
  - `spec_ghr_o` = 0.
  - `spec_o.taken` = `fetch_valid_i & (J|CJ) & limit`, since the B/CB counter reads weak-NT.
- `fetch_valid_i=0`: `spec_o.taken=0`. `spec_o.pc` is don't-care but must be deterministic (the adder result).
- Stall (`fetch_ready_i=0` with `fetch_valid_i=1`): the prediction is still produced and the GHR holds. No double shift.
- An update with `upd_valid_i=0` has no effect, whatever the other upd inputs are.

## Test plan
- **JAL:** after reset, fetch 0x0080006f at PC 0x4000_0000 → `taken=1`, `pc=0x4000_0008`, `spec_ghr_o` unchanged (0).
- **C.J:** fetch 0xBFFD (offset −2) at PC 0x0000_0200 → `taken=1`, `pc=0x0000_01FE`. The same JAL at PC 0x4000_3CF8 with +8 gives target 0x4000_3D00 → `taken=0`.
- **Bimodal saturation** (`HIST_LEN=0`), BEQ at PC 0x100, fresh reset:
  - Initially → `taken=0`.
  - After 1 taken update → `taken=1` (10).
  - After 3 more taken updates → still 11.
  - After 2 not-taken updates → `taken=0` (01).
  - After 5 more not-taken updates → 00, and 2 taken updates are needed to predict taken.
- **GHR shift and stall** (`HIST_LEN=8`): fetch BEQ with `fetch_ready_i=0` for 3 cycles, then 1 → GHR goes 0x00 to 0x00 (one shift of 0, not four). Then a predicted-taken branch → GHR shifts in 1.
- **Mispredict restore:** GHR=0x3C, `upd_mispredict_i=1`, `upd_ghr_i=0x5A`, `upd_taken_i=1` → next cycle `spec_ghr_o=0xB5`. With a simultaneous fetch of a BNE and `fetch_ready_i=1`, the result is still 0xB5.
- **Async reset mid-operation:** train several entries and set GHR=0xFF, then pulse `rst_ni` low between clock edges → `spec_ghr_o=0` immediately, and all B fetches predict not-taken.
